// File: rtl/wbr_sd2_segment.sv
// Wrapper boundary register segment: WIDTH shift/update cells on one serial path,
// with safe-value override, reload path, shift-occupancy counter and sticky control-conflict flag.

module wbr_sd2_cell (
    input  logic clk,
    input  logic arst,
    input  logic shift,
    input  logic capture,
    input  logic transfer,
    input  logic update,
    input  logic si,
    input  logic cap_d,
    output logic s_q,
    output logic u_q
);
    // Update samples the pre-edge shift bit regardless of which shift-stage op wins.
    always_ff @(posedge clk) begin
        if (arst) begin
            s_q <= 1'b0;
            u_q <= 1'b0;
        end else begin
            if (shift)
                s_q <= si;
            else if (capture)
                s_q <= cap_d;
            else if (transfer)
                s_q <= u_q;
            if (update)
                u_q <= s_q;
        end
    end
endmodule

module wbr_sd2_segment #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   SAFE_VALUE = {WIDTH{1'b0}},
    localparam int                CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] cfi,
    output logic [WIDTH-1:0] cfo,
    input  logic             cti,
    output logic             cto,
    input  logic             shift,
    input  logic             capture,
    input  logic             transfer,
    input  logic             update,
    input  logic             io_face,
    input  logic             mode,
    input  logic             safe,
    output logic [CW-1:0]    shift_cnt,
    output logic             seg_full,
    output logic             ctl_err
);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] ureg;
    logic [WIDTH-1:0] ser_in;
    logic [WIDTH-1:0] cap_d;
    logic             conflict;

    assign ser_in = {sreg[WIDTH-2:0], cti};
    // io_face=1 observes the value currently driven toward the core, safe override included.
    assign cap_d  = io_face ? cfo : cfi;

    always_comb begin
        cfo = cfi;
        if (mode)
            cfo = safe ? SAFE_VALUE : ureg;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        wbr_sd2_cell u_cell (
            .clk      (clk),
            .arst     (arst),
            .shift    (shift),
            .capture  (capture),
            .transfer (transfer),
            .update   (update),
            .si       (ser_in[i]),
            .cap_d    (cap_d[i]),
            .s_q      (sreg[i]),
            .u_q      (ureg[i])
        );
    end

    assign cto      = sreg[WIDTH-1];
    assign seg_full = (shift_cnt == CNT_MAX);
    assign conflict = (shift & capture) | (shift & transfer) | (capture & transfer);

    always_ff @(posedge clk) begin
        if (arst) begin
            shift_cnt <= '0;
            ctl_err   <= 1'b0;
        end else begin
            if (shift) begin
                if (shift_cnt != CNT_MAX)
                    shift_cnt <= shift_cnt + 1'b1;
            end else if (capture || transfer) begin
                shift_cnt <= '0;
            end
            if (conflict)
                ctl_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wbr_sd2_segment.sv
// Bench for wbr_sd2_segment: directed scenarios plus randomized traffic against a value-level model.

module tb_wbr_sd2_segment;
    localparam int         W    = 8;
    localparam logic [7:0] SAFE = 8'hC3;

    logic       clk = 1'b0;
    logic       arst, cti, shift, capture, transfer, update, io_face, mode, safe;
    logic [7:0] cfi, cfo;
    logic       cto, seg_full, ctl_err;
    logic [3:0] shift_cnt;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [7:0] m_sreg, m_ureg;
    int         m_cnt;
    bit         m_err;

    always #5 clk = ~clk;

    wbr_sd2_segment #(.WIDTH(W), .SAFE_VALUE(SAFE)) dut (
        .clk(clk), .arst(arst), .cfi(cfi), .cfo(cfo), .cti(cti), .cto(cto),
        .shift(shift), .capture(capture), .transfer(transfer), .update(update),
        .io_face(io_face), .mode(mode), .safe(safe),
        .shift_cnt(shift_cnt), .seg_full(seg_full), .ctl_err(ctl_err)
    );

    function automatic logic [7:0] m_cfo();
        if (!mode) return cfi;
        return safe ? SAFE : m_ureg;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cto"},  32'(cto),       32'(m_sreg[7]));
        check({tag, ".cfo"},  32'(cfo),       32'(m_cfo()));
        check({tag, ".cnt"},  32'(shift_cnt), 32'(m_cnt));
        check({tag, ".full"}, 32'(seg_full),  32'(m_cnt == W));
        check({tag, ".err"},  32'(ctl_err),   32'(m_err));
    endtask

    // One clock edge: model advances from the inputs present at the edge, then all outputs checked.
    task automatic cyc(input string tag);
        logic [7:0] ns, nu;
        int         nc, nops;
        bit         ne;
        nops = int'(shift) + int'(capture) + int'(transfer);
        ns = shift ? {m_sreg[6:0], cti} : capture ? (io_face ? m_cfo() : cfi)
           : transfer ? m_ureg : m_sreg;
        nu = update ? m_sreg : m_ureg;
        nc = shift ? ((m_cnt + 1 > W) ? W : m_cnt + 1) : (capture || transfer) ? 0 : m_cnt;
        ne = m_err || (nops >= 2);
        if (arst) begin ns = '0; nu = '0; nc = 0; ne = 1'b0; end
        @(posedge clk);
        m_sreg = ns; m_ureg = nu; m_cnt = nc; m_err = ne;
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        arst = 0; shift = 0; capture = 0; transfer = 0; update = 0; cti = 0;
    endtask

    // Shifts a byte in MSB first so it lands in sreg with natural bit order.
    task automatic load_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            idle(); shift = 1; cti = v[i];
            cyc("load");
        end
        idle();
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  old_s;
        m_sreg = '0; m_ureg = '0; m_cnt = 0; m_err = 0;
        cfi = 8'h00; io_face = 0; mode = 0; safe = 0; idle();

        // 1: reset wins over random controls
        @(posedge clk); #1;
        arst = 1; {shift, capture, transfer, update, cti} = 5'($urandom);
        cfi = 8'($urandom);
        cyc("reset");
        arst = 0; mode = 1; safe = 0;
        #1 check("reset.cfo_ureg", 32'(cfo), 32'h0);
        safe = 1;
        #1 check("reset.cfo_safe", 32'(cfo), 32'(SAFE));
        mode = 0; safe = 0; idle();

        // 2: shift-through of A5 then 3C, LSB first
        pat = 16'h3CA5;
        for (int i = 0; i < 16; i++) begin
            idle(); shift = 1; cti = pat[i];
            cyc("shift");
            if (i >= 7) check("shift.cto_stream", 32'(cto), 32'(pat[i-7]));
            check("shift.cnt_sat", 32'(shift_cnt), 32'((i + 1 > 8) ? 8 : i + 1));
        end
        idle();

        // 3: capture cfi, update, observe through cfo while cfi moves
        cfi = 8'h5A; io_face = 0; capture = 1;
        cyc("cap");
        check("cap.cnt_clear", 32'(shift_cnt), 32'h0);
        idle(); update = 1; mode = 1; safe = 0;
        cyc("upd");
        idle(); cfi = 8'hFF;
        #1 check("upd.cfo", 32'(cfo), 32'h5A);

        // 4: safe override and functional pass-through
        safe = 1;
        #1 check("safe.cfo", 32'(cfo), 32'hC3);
        mode = 0; cfi = 8'h11;
        #1 check("func.cfo11", 32'(cfo), 32'h11);
        cfi = 8'h22;
        #1 check("func.cfo22", 32'(cfo), 32'h22);

        // 5: io_face capture of driven value, then transfer reload
        load_byte(8'h96);
        update = 1; cyc("ld96"); idle();
        mode = 1; safe = 0; io_face = 1; cfi = 8'h00;
        load_byte(8'h0F);
        capture = 1; cyc("capio"); idle();
        check("capio.cto", 32'(cto), 32'h1);
        for (int i = 0; i < 3; i++) begin shift = 1; cti = 1'($urandom); cyc("garb"); end
        idle(); transfer = 1; cyc("xfer"); idle();
        check("xfer.cnt", 32'(shift_cnt), 32'h0);
        update = 1; cyc("xfer_upd"); idle();
        #1 check("xfer.sreg", 32'(cfo), 32'h96);

        // 6: conflicts and update coinciding with shift
        shift = 1; capture = 1; cti = 1; cyc("conf");
        check("conf.err", 32'(ctl_err), 32'h1);
        idle(); load_byte(8'hE4);
        old_s = 8'hE4;
        shift = 1; update = 1; cti = 0; cyc("upd_shift"); idle();
        #1 check("upd_shift.cfo", 32'(cfo), 32'(old_s));
        check("conf.sticky", 32'(ctl_err), 32'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            arst     = ($urandom_range(0, 39) == 0);
            shift    = ($urandom_range(0, 2) == 0);
            capture  = ($urandom_range(0, 5) == 0);
            transfer = ($urandom_range(0, 7) == 0);
            update   = ($urandom_range(0, 3) == 0);
            cti      = 1'($urandom);
            io_face  = 1'($urandom);
            mode     = 1'($urandom);
            safe     = ($urandom_range(0, 3) == 0);
            cfi      = 8'($urandom);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
